// File: rtl/mux_4to1_rr.sv
// mux_4to1_rr: merges four valid/ready streams into one registered output
// stream using round-robin arbitration, and tags each beat with its channel.
module mux_4to1_rr #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          in_valid,
  input  logic [4*DATA_W-1:0] in_data,
  output logic [3:0]          in_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_sel,
  input  logic                out_ready
);

  logic [1:0]        ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_sel_q, out_sel_d;

  logic       load_en;
  logic [3:0] rot;
  logic [3:0] first;
  logic [1:0] off;
  logic [1:0] grant;
  logic       take;

  // Requests rotated so bit 0 is the channel at ptr; the lowest set bit
  // of the rotated vector is then the next channel in search order.
  always_comb begin
    load_en = !out_valid_q || out_ready;
    for (int j = 0; j < 4; j++) begin
      rot[j] = in_valid[2'(ptr_q + 2'(j))];
    end
    first = rot & (~rot + 4'd1);
    unique case (1'b1)
      first[0]: off = 2'd0;
      first[1]: off = 2'd1;
      first[2]: off = 2'd2;
      first[3]: off = 2'd3;
      default:  off = 2'd0;
    endcase
    grant = ptr_q + off;
    if (load_en && (|in_valid)) begin
      in_ready = 4'b0001 << grant;
    end else begin
      in_ready = 4'b0000;
    end
    take = |in_ready;
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (take) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[grant*DATA_W +: DATA_W];
      out_sel_d   = grant;
      ptr_d       = grant + 2'd1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_4to1_rr.sv
// tb_mux_4to1_rr: directed vectors plus a random scoreboard run, checked
// every cycle against a behavioural arbiter model.
module tb_mux_4to1_rr;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [3:0]     in_valid = '0;
  logic [4*W-1:0] in_data = '0;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready = 1'b0;

  int nchk = 0;
  int nerr = 0;

  mux_4to1_rr #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a held beat (m_valid/m_data/m_sel) and a pointer; grant is the
  // first valid channel walking up from the pointer, if the slot is free.
  logic         m_valid;
  logic [W-1:0] m_data;
  logic [1:0]   m_sel;
  logic [1:0]   m_ptr;
  logic [3:0]   m_rdy;
  logic [W-1:0] sbq [4][$];

  function automatic logic [3:0] exp_ready(logic [3:0] v, logic ordy,
                                           logic mv, logic [1:0] p);
    if (mv && !ordy) return 4'b0000;
    for (int j = 0; j < 4; j++) begin
      int c;
      c = (int'(p) + j) % 4;
      if (v[c]) return 4'(1 << c);
    end
    return 4'b0000;
  endfunction

  assign m_rdy = exp_ready(in_valid, out_ready, m_valid, m_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sel   <= 2'd0;
      m_ptr   <= 2'd0;
    end else begin
      if (m_rdy == 4'b0000 && m_valid && out_ready) m_valid <= 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (m_rdy[c]) begin
          m_valid <= 1'b1;
          m_data  <= in_data[c*W +: W];
          m_sel   <= 2'(c);
          m_ptr   <= 2'((c + 1) % 4);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(m_rdy));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_sel", 32'(out_sel), 32'(m_sel));
      end
      chk("ptr", 32'(dut.ptr_q), 32'(m_ptr));
      if (out_valid && out_ready) begin
        if (sbq[out_sel].size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL sb_dup: beat %0h on ch%0d not queued",
                   out_data, out_sel);
        end else begin
          chk("sb_order", 32'(out_data), 32'(sbq[out_sel].pop_front()));
        end
      end
      for (int c = 0; c < 4; c++) begin
        if (in_valid[c] && in_ready[c]) sbq[c].push_back(in_data[c*W +: W]);
      end
    end else begin
      for (int c = 0; c < 4; c++) sbq[c].delete();
    end
  end

  task automatic half();
    @(negedge clk);
    #2;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] cnt [4];
  logic [3:0]   acc;

  initial begin
    half();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sel", 32'(out_sel), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    next();
    rst_n = 1'b1;
    // single channel
    in_valid = 4'b0100;
    in_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    out_ready = 1'b1;
    half();
    chk("single_rdy", 32'(in_ready), 32'b0100);
    next();
    in_valid = 4'b0000;
    half();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'hA5);
    chk("single_sel", 32'(out_sel), 32'd2);
    chk("single_ptr", 32'(dut.ptr_q), 32'd3);
    // wrap and skip
    next();
    in_valid = 4'b0011;
    in_data = {8'h00, 8'h00, 8'hB1, 8'hB0};
    half();
    chk("wrap_rdy0", 32'(in_ready), 32'b0001);
    next();
    half();
    chk("wrap_sel0", 32'(out_sel), 32'd0);
    chk("wrap_ptr1", 32'(dut.ptr_q), 32'd1);
    chk("wrap_rdy1", 32'(in_ready), 32'b0010);
    next();
    in_valid = 4'b0000;
    half();
    chk("wrap_sel1", 32'(out_sel), 32'd1);
    chk("wrap_data1", 32'(out_data), 32'hB1);
    chk("wrap_ptr2", 32'(dut.ptr_q), 32'd2);
    // bring ptr back to 0 through channel 3
    next();
    in_valid = 4'b1000;
    next();
    in_valid = 4'b1111;
    in_data = {8'h43, 8'h32, 8'h21, 8'h10};
    for (int i = 0; i < 8; i++) begin
      next();
      chk("rr_sel", 32'(out_sel), 32'(i % 4));
      chk("rr_data", 32'(out_data), 32'(8'h10 + 8'h11 * (i % 4)));
      chk("rr_valid", 32'(out_valid), 32'd1);
    end
    // backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      half();
      chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_sel", 32'(out_sel), 32'd3);
      chk("bp_data", 32'(out_data), 32'h43);
      chk("bp_ptr", 32'(dut.ptr_q), 32'd0);
      next();
    end
    out_ready = 1'b1;
    half();
    chk("bp_resume_rdy", 32'(in_ready), 32'b0001);
    next();
    chk("bp_resume_sel", 32'(out_sel), 32'd0);
    chk("bp_resume_data", 32'(out_data), 32'h10);
    // mid-stream reset
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_sel", 32'(out_sel), 32'd0);
    chk("mrst_data", 32'(out_data), 32'd0);
    next();
    rst_n = 1'b1;
    in_valid = 4'b1010;
    half();
    chk("mrst_rdy", 32'(in_ready), 32'b0010);
    next();
    chk("mrst_sel1", 32'(out_sel), 32'd1);
    chk("mrst_data1", 32'(out_data), 32'h21);
    // random scoreboard run
    for (int c = 0; c < 4; c++) cnt[c] = 8'(c * 64);
    for (int n = 0; n < 1000; n++) begin
      in_valid = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      in_data = {cnt[3], cnt[2], cnt[1], cnt[0]};
      half();
      acc = in_valid & in_ready;
      next();
      for (int c = 0; c < 4; c++) if (acc[c]) cnt[c] = cnt[c] + 8'd1;
    end
    in_valid = 4'b0000;
    out_ready = 1'b1;
    repeat (3) next();
    half();
    for (int c = 0; c < 4; c++) chk("sb_left", 32'(sbq[c].size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
